br_amba_axil_reg_target: RTL and testbench
==========================================

# br_amba_axil_reg_target

AXI4-Lite subordinate endpoint that terminates an AXI4-Lite link and converts accepted transactions into a simple single-outstanding register request/response interface for a local register block. It sits at the far end of an AXI4-Lite path, after any fabric and pipeline stages. It performs address range checking, read/write arbitration, error mapping and response timeout.

## Interface
- AddrWidth, 40, AXI address width (≥ 12)
- DataWidth, 64, data width; 32 or 64 only
- BaseAddr, 0, byte base of decoded window; aligned to SizeBytes
- SizeBytes, 4096, window size; power of two, ≥ DataWidth/8
- TimeoutCycles, 256, max cycles awaiting resp_valid; 0 disables timeout
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- target_aw{addr,prot,valid}/awready  in/out  AddrWidth/br_amba::AxiProtWidth/1/1  write address channel
- target_w{data,strb,valid}/wready  in/out  DataWidth/DataWidth/8/1/1  write data channel
- target_b{resp,valid}  out  br_amba::AxiRespWidth/1; target_bready in 1
- target_ar{addr,prot,valid}/arready  in/out  AddrWidth/br_amba::AxiProtWidth/1/1  read address channel
- target_r{data,resp,valid}  out  DataWidth/br_amba::AxiRespWidth/1; target_rready in 1
- req_valid  out  1  register request valid
- req_ready  in  1  register block accepts request
- req_write  out  1  1 = write, 0 = read
- req_addr  out  $clog2(SizeBytes)  word-aligned byte offset within window
- req_wdata  out  DataWidth  write data; req_wstrb out DataWidth/8 byte enables
- resp_valid  in  1  single-cycle response pulse
- resp_rdata  in  DataWidth  read data; resp_err in 1  register-block error

## Operation
- One transaction in flight. States: IDLE, REQ, WAIT, BRESP, RRESP.
- IDLE: write candidate = awvalid & wvalid; read candidate = arvalid. If both, grant alternates via prio_rd flop (reset 0 → write wins first); granted type flips prio_rd.
- Grant: assert awready and wready together (write) or arready (read) combinationally in IDLE only; capture addr/data/strb/direction.
- Decode: in-range iff BaseAddr ≤ addr < BaseAddr+SizeBytes. Out-of-range → skip REQ/WAIT, go to BRESP/RRESP with DECERR (2'b11), rdata 0.
- REQ: req_valid=1, payload stable until req_ready; then WAIT.
- WAIT: on resp_valid capture rdata and err → BRESP (write) or RRESP (read); resp SLVERR (2'b10) if err else OKAY (2'b00).
- Timeout: counter cleared on REQ handshake, incremented each WAIT cycle; at TimeoutCycles with no resp_valid → SLVERR, rdata 0. resp_valid outside WAIT is ignored (late responses dropped).
- BRESP/RRESP: hold bvalid/rvalid with stable payload until ready → IDLE.
- awprot/arprot accepted and ignored. Response encodings from br_amba.

## Timing
- Reset values: all readies 0, bvalid 0, rvalid 0, req_valid 0, bresp/rresp 0, rdata 0, req payload 0, prio_rd 0, counter 0, state IDLE.
- Address/data grant cycle N (IDLE) → req_valid at N+1. req_ready with resp_valid at cycle M → b/rvalid at M+1.
- Min in-range latency: grant to response valid = 3 cycles with req_ready and resp_valid asserted in the earliest possible cycle.
- DECERR: grant N → b/rvalid at N+1.
- bready/rready high while valid: back to IDLE next cycle; new grant possible in that same IDLE cycle.
- AW without W (or vice versa) is never accepted alone; no ready asserted.
- resp_valid in the same cycle as the req_ready handshake is not legal from the register block; req→resp ≥ 1 cycle.
- Async reset mid-transaction aborts everything; no response is issued for the aborted transaction.

## Structure
- br_amba: add AxiRespOkay=2'b00, AxiRespSlverr=2'b10, AxiRespDecerr=2'b11 beside existing width constants.
- State enum local to module. No sub-module; single flat module.
- Elaboration asserts on DataWidth, SizeBytes power of two, BaseAddr alignment.

## Test plan
- Write addr=BaseAddr+0x10, data=0xDEAD_BEEF, strb=0xF0, req_ready=1, resp in 1 cycle -> req_addr=0x10, req_wstrb=0xF0, bresp=OKAY, bvalid 3 cycles after grant.
- Read addr=BaseAddr+0x8, resp_rdata=0x1234, resp_err=1 -> rresp=SLVERR, rdata=0x1234.
- AW+W and AR valid simultaneously twice -> first write, then read granted; order W,R,W,R sustained.
- Read addr=BaseAddr+SizeBytes -> no req_valid, rresp=DECERR, rdata=0, one cycle after grant.
- TimeoutCycles=4, no resp_valid -> rresp=SLVERR after 4 WAIT cycles; later resp_valid pulse ignored.
- bready low 5 cycles, then rst_n asserted -> bvalid drops immediately; after release all outputs at reset values, next write handled normally.

Source files
------------

// File: rtl/br_amba_pkg.sv
// br_amba: shared AMBA constants and response encodings.
//   AxiProtWidth / AxiRespWidth : channel field widths
//   AxiResp*                    : xRESP encodings used by AXI4-Lite endpoints
package br_amba;

  localparam int unsigned AxiProtWidth = 3;
  localparam int unsigned AxiRespWidth = 2;

  typedef logic [AxiRespWidth-1:0] axi_resp_t;

  localparam axi_resp_t AxiRespOkay   = 2'b00;
  localparam axi_resp_t AxiRespExokay = 2'b01;
  localparam axi_resp_t AxiRespSlverr = 2'b10;
  localparam axi_resp_t AxiRespDecerr = 2'b11;

endpackage

// File: rtl/br_amba_axil_reg_target.sv
// br_amba_axil_reg_target: AXI4-Lite subordinate terminating a link into a single-outstanding
// register request/response interface.
//   target_aw* / target_w* / target_b* : AXI4-Lite write channels
//   target_ar* / target_r*             : AXI4-Lite read channels
//   req_*                              : register request (valid/ready, payload held while valid)
//   resp_*                             : single-cycle register response (only honoured in WAIT)
// Out-of-window addresses are answered with DECERR without touching the register block; a
// missing response is answered with SLVERR after TimeoutCycles WAIT cycles (0 disables).
module br_amba_axil_reg_target
  import br_amba::*;
#(
  parameter int unsigned          AddrWidth     = 40,
  parameter int unsigned          DataWidth     = 64,
  parameter logic [AddrWidth-1:0] BaseAddr      = '0,
  parameter int unsigned          SizeBytes     = 4096,
  parameter int unsigned          TimeoutCycles = 256,
  localparam int unsigned         StrbWidth     = DataWidth / 8,
  localparam int unsigned         OffWidth      = $clog2(SizeBytes)
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [AddrWidth-1:0]    target_awaddr,
  input  logic [AxiProtWidth-1:0] target_awprot,
  input  logic                    target_awvalid,
  output logic                    target_awready,
  input  logic [DataWidth-1:0]    target_wdata,
  input  logic [StrbWidth-1:0]    target_wstrb,
  input  logic                    target_wvalid,
  output logic                    target_wready,
  output logic [AxiRespWidth-1:0] target_bresp,
  output logic                    target_bvalid,
  input  logic                    target_bready,

  input  logic [AddrWidth-1:0]    target_araddr,
  input  logic [AxiProtWidth-1:0] target_arprot,
  input  logic                    target_arvalid,
  output logic                    target_arready,
  output logic [DataWidth-1:0]    target_rdata,
  output logic [AxiRespWidth-1:0] target_rresp,
  output logic                    target_rvalid,
  input  logic                    target_rready,

  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [OffWidth-1:0]     req_addr,
  output logic [DataWidth-1:0]    req_wdata,
  output logic [StrbWidth-1:0]    req_wstrb,
  input  logic                    resp_valid,
  input  logic [DataWidth-1:0]    resp_rdata,
  input  logic                    resp_err
);

  // Elaboration-time parameter checks.
  if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_data_width
    $error("DataWidth must be 32 or 64");
  end
  if (AddrWidth < 12) begin : g_bad_addr_width
    $error("AddrWidth must be at least 12");
  end
  if (SizeBytes == 0 || (SizeBytes & (SizeBytes - 1)) != 0) begin : g_bad_size
    $error("SizeBytes must be a power of two");
  end
  if (SizeBytes < StrbWidth) begin : g_small_size
    $error("SizeBytes must cover at least one data word");
  end
  if ((BaseAddr & AddrWidth'(SizeBytes - 1)) != '0) begin : g_bad_base
    $error("BaseAddr must be aligned to SizeBytes");
  end

  localparam int unsigned CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] CntLast =
      CntWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  // One extra bit so BaseAddr + SizeBytes cannot wrap at the top of the address space.
  localparam logic [AddrWidth:0] WinLo = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0] WinHi = WinLo + (AddrWidth + 1)'(SizeBytes);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StBresp, StRresp} state_e;

  function automatic logic in_window(input logic [AddrWidth-1:0] a);
    return ({1'b0, a} >= WinLo) && ({1'b0, a} < WinHi);
  endfunction

  // BaseAddr is SizeBytes-aligned, so the low address bits already form the window offset.
  function automatic logic [OffWidth-1:0] word_offset(input logic [AddrWidth-1:0] a);
    return a[OffWidth-1:0] & ~OffWidth'(StrbWidth - 1);
  endfunction

  state_e                state_q;
  logic                  prio_rd_q;
  logic                  write_q;
  logic [OffWidth-1:0]   addr_q;
  logic [DataWidth-1:0]  wdata_q;
  logic [StrbWidth-1:0]  wstrb_q;
  logic [DataWidth-1:0]  rdata_q;
  axi_resp_t             resp_q;
  logic [CntWidth-1:0]   cnt_q;

  logic                  wr_cand, rd_cand;
  logic                  grant_wr, grant_rd;
  logic [AddrWidth-1:0]  gnt_addr;

  // Protection attributes carry no meaning for this endpoint.
  logic unused_prot;
  assign unused_prot = ^{target_awprot, target_arprot};

  always_comb begin
    wr_cand  = target_awvalid & target_wvalid;
    rd_cand  = target_arvalid;
    grant_wr = (state_q == StIdle) & wr_cand & (~rd_cand | ~prio_rd_q);
    grant_rd = (state_q == StIdle) & rd_cand & (~wr_cand | prio_rd_q);
    gnt_addr = grant_wr ? target_awaddr : target_araddr;
  end

  assign target_awready = grant_wr;
  assign target_wready  = grant_wr;
  assign target_arready = grant_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prio_rd_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= AxiRespOkay;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_wr || grant_rd) begin
            write_q   <= grant_wr;
            prio_rd_q <= grant_wr;
            addr_q    <= word_offset(gnt_addr);
            wdata_q   <= grant_wr ? target_wdata : '0;
            wstrb_q   <= grant_wr ? target_wstrb : '0;
            if (in_window(gnt_addr)) begin
              state_q <= StReq;
            end else begin
              resp_q  <= AxiRespDecerr;
              rdata_q <= '0;
              state_q <= grant_wr ? StBresp : StRresp;
            end
          end
        end
        StReq: begin
          if (req_ready) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (resp_valid) begin
            rdata_q <= resp_rdata;
            resp_q  <= resp_err ? AxiRespSlverr : AxiRespOkay;
            state_q <= write_q ? StBresp : StRresp;
          end else if (TimeoutEn && cnt_q == CntLast) begin
            rdata_q <= '0;
            resp_q  <= AxiRespSlverr;
            state_q <= write_q ? StBresp : StRresp;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
        end
        StBresp: begin
          if (target_bready) state_q <= StIdle;
        end
        StRresp: begin
          if (target_rready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_valid     = (state_q == StReq);
  assign req_write     = write_q;
  assign req_addr      = addr_q;
  assign req_wdata     = wdata_q;
  assign req_wstrb     = wstrb_q;
  assign target_bvalid = (state_q == StBresp);
  assign target_rvalid = (state_q == StRresp);
  assign target_bresp  = resp_q;
  assign target_rresp  = resp_q;
  assign target_rdata  = rdata_q;

endmodule

// File: tb/tb_br_amba_axil_reg_target.sv
// Self-checking bench for br_amba_axil_reg_target: a register-block model answers requests,
// a monitor pops scoreboard entries when b/r responses handshake.
module tb_br_amba_axil_reg_target;
  import br_amba::*;

  localparam int unsigned AW = 40;
  localparam int unsigned DW = 64;
  localparam logic [AW-1:0] Base = 40'h1000;
  localparam int unsigned Size = 4096;

  typedef struct {
    bit          wr;
    logic [1:0]  resp;
    logic [63:0] data;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic awready, wready, arready, bvalid, rvalid;
  logic [DW-1:0] wdata = '0, rdata;
  logic [7:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic req_valid, req_ready, req_write, resp_valid, resp_err;
  logic [11:0] req_addr;
  logic [DW-1:0] req_wdata, resp_rdata;
  logic [7:0] req_wstrb;

  int checks = 0, errors = 0, cyc = 0, resp_cnt = 0, req_cnt = 0;
  exp_t exp_q[$];
  int gcyc_q[$];
  bit glog[$];
  req_t req_log[$];

  bit rb_silent = 0, rb_busy = 0, rb_err = 0;
  int rb_late = 8;
  logic [63:0] rb_rdata = '0;

  br_amba_axil_reg_target #(
    .AddrWidth(AW), .DataWidth(DW), .BaseAddr(Base), .SizeBytes(Size), .TimeoutCycles(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .target_awaddr(awaddr), .target_awprot(awprot), .target_awvalid(awvalid),
    .target_awready(awready),
    .target_wdata(wdata), .target_wstrb(wstrb), .target_wvalid(wvalid), .target_wready(wready),
    .target_bresp(bresp), .target_bvalid(bvalid), .target_bready(bready),
    .target_araddr(araddr), .target_arprot(arprot), .target_arvalid(arvalid),
    .target_arready(arready),
    .target_rdata(rdata), .target_rresp(rresp), .target_rvalid(rvalid), .target_rready(rready),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Register-block model: accepts every request, answers one cycle later (or late when silent).
  initial begin
    req_t r;
    req_ready = 1'b1; resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && req_ready) begin
        r.wr = req_write; r.addr = req_addr; r.wdata = req_wdata; r.wstrb = req_wstrb;
        req_log.push_back(r);
        req_cnt++;
        rb_busy = 1;
        if (rb_silent) repeat (rb_late) @(posedge clk);
        else @(posedge clk);
        #1;
        resp_valid = 1'b1; resp_rdata = rb_rdata; resp_err = rb_err;
        @(posedge clk); #1;
        resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0;
        rb_busy = 0;
      end
    end
  end

  // Grant logging and scoreboard pop on response handshake.
  initial begin
    exp_t e;
    int gc;
    bit is_wr;
    logic [1:0] got_resp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (awvalid && wvalid && awready && wready) begin
          gcyc_q.push_back(cyc); glog.push_back(1'b1);
        end
        if (arvalid && arready) begin
          gcyc_q.push_back(cyc); glog.push_back(1'b0);
        end
        if ((bvalid && bready) || (rvalid && rready)) begin
          resp_cnt++;
          is_wr = bvalid;
          got_resp = is_wr ? bresp : rresp;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got wr=%0b resp=%0d with empty scoreboard",
                     is_wr, got_resp);
          end else begin
            e = exp_q.pop_front();
            gc = (gcyc_q.size() != 0) ? gcyc_q.pop_front() : -1000;
            if (is_wr !== e.wr) begin
              errors++;
              $display("FAIL %s_type: got wr=%0b required wr=%0b", e.name, is_wr, e.wr);
            end
            checks++;
            if (got_resp !== e.resp) begin
              errors++;
              $display("FAIL %s_resp: got %0d required %0d", e.name, got_resp, e.resp);
            end
            if (!e.wr) begin
              checks++;
              if (rdata !== e.data) begin
                errors++;
                $display("FAIL %s_rdata: got %h required %h", e.name, rdata, e.data);
              end
            end
            if (e.lat >= 0) begin
              checks++;
              if (cyc - gc != e.lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d required %0d", e.name, cyc - gc, e.lat);
              end
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input bit wr, input logic [1:0] resp, input logic [63:0] data,
                          input int lat, input string name);
    exp_t e;
    e.wr = wr; e.resp = resp; e.data = data; e.lat = lat; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [63:0] data,
                       input logic [7:0] strb, output bit ok);
    @(posedge clk); #1;
    if (wr) begin
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    end else begin
      araddr = addr; arvalid = 1;
    end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = wr ? (awready && wready) : arready;
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
  endtask

  task automatic wait_resp(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (resp_cnt >= target) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b required 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, req_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_valid: got %b required 000", {bvalid, rvalid, req_valid});
    end
    checks++;
    if ({bresp, rresp, rdata, req_addr, req_wdata, req_wstrb, req_write} !== '0) begin
      errors++;
      $display("FAIL reset_payload: bresp=%0d rresp=%0d rdata=%h addr=%h wdata=%h strb=%h",
               bresp, rresp, rdata, req_addr, req_wdata, req_wstrb);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_write();
    bit ok;
    req_log.delete();
    push_exp(1, AxiRespOkay, '0, 3, "write_okay");
    issue(1, Base + 40'h10, 64'hDEAD_BEEF, 8'hF0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_grant: got no grant required grant"); end
    wait_resp(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_wait: got no bvalid required bvalid"); end
    checks++;
    if (req_log.size() != 1 || req_log[0].wr !== 1'b1 || req_log[0].addr !== 12'h010 ||
        req_log[0].wstrb !== 8'hF0 || req_log[0].wdata !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_req: got n=%0d required one write addr=010 strb=f0 data=deadbeef",
               req_log.size());
    end
  endtask

  task automatic test_read();
    bit ok;
    req_log.delete();
    rb_rdata = 64'h1234; rb_err = 1;
    push_exp(0, AxiRespSlverr, 64'h1234, 3, "read_slverr");
    issue(0, Base + 40'h8, '0, '0, ok);
    wait_resp(resp_cnt + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL read_wait: got no rvalid required rvalid"); end
    checks++;
    if (req_log.size() != 1 || req_log[0].wr !== 1'b0 || req_log[0].addr !== 12'h008) begin
      errors++;
      $display("FAIL read_req: got n=%0d required one read at offset 008", req_log.size());
    end
    rb_err = 0;
  endtask

  task automatic test_aw_w_alone();
    bit bad = 0;
    int g0 = glog.size();
    int r0 = req_cnt;
    @(posedge clk); #1;
    awaddr = Base; awvalid = 1;
    repeat (4) begin
      @(negedge clk);
      if (awready || wready || arready) bad = 1;
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 1;
    repeat (4) begin
      @(negedge clk);
      if (awready || wready || arready) bad = 1;
    end
    @(posedge clk); #1;
    wvalid = 0;
    checks++;
    if (bad) begin errors++; $display("FAIL lone_channel_ready: got ready required none"); end
    checks++;
    if (glog.size() != g0 || req_cnt != r0) begin
      errors++;
      $display("FAIL lone_channel_accept: got grants=%0d reqs=%0d required 0",
               glog.size() - g0, req_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok = 0;
    int g0 = glog.size();
    int c0 = resp_cnt;
    bit got_order[4];
    rb_rdata = 64'hA5A5;
    push_exp(1, AxiRespOkay, '0, 3, "arb_w0");
    push_exp(0, AxiRespOkay, 64'hA5A5, 3, "arb_r0");
    push_exp(1, AxiRespOkay, '0, 3, "arb_w1");
    push_exp(0, AxiRespOkay, 64'hA5A5, 3, "arb_r1");
    @(posedge clk); #1;
    awaddr = Base + 40'h100; wdata = 64'h1111; wstrb = 8'h0F; araddr = Base + 40'h108;
    awvalid = 1; wvalid = 1; arvalid = 1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (glog.size() >= g0 + 4) begin
        ok = 1;
        break;
      end
    end
    #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL arb_grants: got %0d required 4", glog.size() - g0); end
    wait_resp(c0 + 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL arb_resps: got %0d required 4", resp_cnt - c0); end
    for (int i = 0; i < 4; i++) got_order[i] = (glog.size() > g0 + i) ? glog[g0 + i] : 1'b0;
    checks++;
    if ({got_order[0], got_order[1], got_order[2], got_order[3]} !== 4'b1010) begin
      errors++;
      $display("FAIL arb_order: got %b required 1010 (1=write)",
               {got_order[0], got_order[1], got_order[2], got_order[3]});
    end
  endtask

  task automatic test_decerr();
    bit ok;
    int r0 = req_cnt;
    req_log.delete();
    push_exp(0, AxiRespDecerr, '0, 1, "decerr_read_top");
    issue(0, Base + Size, '0, '0, ok);
    wait_resp(resp_cnt + 1, ok);
    push_exp(1, AxiRespDecerr, '0, 1, "decerr_write_below");
    issue(1, Base - 40'h8, 64'h99, 8'hFF, ok);
    wait_resp(resp_cnt + 1, ok);
    checks++;
    if (req_cnt != r0) begin
      errors++; $display("FAIL decerr_no_req: got %0d requests required 0", req_cnt - r0);
    end
    rb_rdata = 64'h77;
    push_exp(0, AxiRespOkay, 64'h77, 3, "last_word_read");
    issue(0, Base + Size - 8, '0, '0, ok);
    wait_resp(resp_cnt + 1, ok);
    checks++;
    if (req_log.size() != 1 || req_log[0].addr !== 12'hFF8) begin
      errors++;
      $display("FAIL last_word_req: got n=%0d required one request at offset ff8",
               req_log.size());
    end
  endtask

  task automatic test_timeout();
    bit ok, bad = 0;
    int c0;
    req_log.delete();
    rb_silent = 1; rb_late = 8; rb_rdata = 64'hBAD;
    push_exp(0, AxiRespSlverr, '0, 6, "timeout_read");
    issue(0, Base + 40'h20, '0, '0, ok);
    wait_resp(resp_cnt + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_wait: got no rvalid required rvalid"); end
    c0 = resp_cnt;
    for (int i = 0; i < 20 && rb_busy; i++) @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      if (bvalid || rvalid || req_valid) bad = 1;
    end
    checks++;
    if (bad || resp_cnt != c0) begin
      errors++;
      $display("FAIL late_resp_ignored: got activity=%0b extra=%0d required none",
               bad, resp_cnt - c0);
    end
    rb_silent = 0; rb_rdata = 64'h42;
    push_exp(0, AxiRespOkay, 64'h42, 3, "after_timeout_read");
    issue(0, Base + 40'h28, '0, '0, ok);
    wait_resp(c0 + 1, ok);
  endtask

  task automatic test_reset_mid_txn();
    bit ok, seen = 0, bad = 0;
    bready = 0;
    push_exp(1, AxiRespOkay, '0, -1, "aborted_write");
    issue(1, Base + 40'h40, 64'h5555, 8'hFF, ok);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bvalid;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL hold_bvalid_seen: got 0 required 1"); end
    repeat (5) begin
      @(negedge clk);
      if (!bvalid || bresp !== AxiRespOkay) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL hold_bvalid_stable: got drop/change required hold"); end
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL async_reset_bvalid: got %b required 0", bvalid);
    end
    exp_q.delete(); gcyc_q.delete();
    @(posedge clk); #1;
    rst_n = 1; bready = 1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, req_valid} !== '0 ||
        {bresp, rresp, rdata, req_addr, req_wdata, req_wstrb, req_write} !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs: bvalid=%b req_valid=%b rdata=%h wdata=%h addr=%h",
               bvalid, req_valid, rdata, req_wdata, req_addr);
    end
    req_log.delete();
    push_exp(1, AxiRespOkay, '0, 3, "post_reset_write");
    issue(1, Base + 40'h48, 64'hCAFE, 8'h3C, ok);
    wait_resp(resp_cnt + 1, ok);
    checks++;
    if (req_log.size() != 1 || req_log[0].addr !== 12'h048 || req_log[0].wstrb !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_req: got n=%0d required one write at 048 strb 3c",
               req_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_aw_w_alone();
    test_back_to_back();
    test_decerr();
    test_timeout();
    test_reset_mid_txn();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
